// File: rtl/midi_uart_tx.sv
// MIDI note-event transmitter: event FIFO feeding a 31250-baud 8N1 UART that
// sends one 3-byte channel message (status, note, velocity) per event.
module midi_uart_tx #(
  parameter int CLK_CYCLES_PER_UART_BIT = 3200,
  parameter int MIDI_CHANNEL            = 0,
  parameter int FIFO_DEPTH              = 4
) (
  input  logic       clk_100mhz,
  input  logic       reset_n,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic       ev_note_on,
  input  logic [6:0] ev_note,
  input  logic [6:0] ev_velocity,
  output logic       tx,
  output logic       busy,
  output logic       byte_done,
  output logic       msg_done
);

  localparam int AW    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW    = AW + 1;
  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_CYCLES_PER_UART_BIT - 1);
  localparam logic [3:0]       CH       = 4'(MIDI_CHANNEL);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO entry: {note_on, note, velocity}
  logic [14:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          ev_ready_q, ev_ready_d;
  logic          push, pop, empty, full_nxt;
  logic [14:0]   head;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [14:0]      msg_q, msg_d;
  logic             tx_q, tx_d, busy_q, busy_d;
  logic             byte_done_q, byte_done_d, msg_done_q, msg_done_d;
  logic [7:0]       cur_byte;
  logic             bit_last;

  assign push  = ev_valid && ev_ready_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    full_nxt   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    ev_ready_d = !full_nxt;
  end

  always_ff @(posedge clk_100mhz) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {ev_note_on, ev_note, ev_velocity};
  end

  always_comb begin
    unique case (byte_idx_q)
      2'd0:    cur_byte = {1'b1, 2'b00, msg_q[14], CH};
      2'd1:    cur_byte = {1'b0, msg_q[13:7]};
      default: cur_byte = {1'b0, msg_q[6:0]};
    endcase
  end

  assign bit_last = (bit_cnt_q == BIT_LAST);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    msg_d       = msg_q;
    pop         = 1'b0;
    byte_done_d = 1'b0;
    msg_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          msg_d      = head;
          byte_idx_d = 2'd0;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_last) begin
          bit_cnt_d   = '0;
          byte_done_d = 1'b1;
          if (byte_idx_q == 2'd2) begin
            msg_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line drivers follow the current state, so tx lags the FSM by one cycle
  // and every bit is still exactly CLK_CYCLES_PER_UART_BIT long.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != IDLE);
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx_q];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ev_ready_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      msg_q       <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      msg_done_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ev_ready_q  <= ev_ready_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      msg_q       <= msg_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
      msg_done_q  <= msg_done_d;
    end
  end

  assign ev_ready  = ev_ready_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign byte_done = byte_done_q;
  assign msg_done  = msg_done_q;

endmodule
